// File: rtl/watch_timekeeper.sv
// 24 h BCD timekeeper driven by the prescaler's 1/10/100 Hz square waves.
// A two-button set mode (debounce and auto-repeat) adjusts the hours and minutes.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  RUN     | 1 Hz ticks advance HH:MM:SS with full carry; inc ignored
//  SET_HR  | seconds held at 00; inc press/repeat bumps hours (23->00)
//  SET_MIN | seconds held at 00; inc press/repeat bumps minutes (59->00)
module watch_timekeeper #(
   parameter int REPEAT_DELAY = 5,
   parameter int DEBOUNCE_N   = 2
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       clk_1hz,
   input  logic       clk_10hz,
   input  logic       clk_100hz,
   input  logic       btn_mode_n,
   input  logic       btn_inc_n,
   output logic [1:0] hr_t,
   output logic [3:0] hr_u,
   output logic [2:0] min_t,
   output logic [3:0] min_u,
   output logic [2:0] sec_t,
   output logic [3:0] sec_u,
   output logic [1:0] mode,
   output logic       blink
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10
   } mode_e;

   localparam logic [2:0] DEB_LAST = 3'(DEBOUNCE_N - 1);
   localparam logic [3:0] REP_THR  = 4'(REPEAT_DELAY);

   logic [2:0] sy_1hz, sy_10hz, sy_100hz;
   logic       tick_1hz, tick_10hz, tick_100hz;
   logic [1:0] btn_s1, btn_s2, btn_deb, btn_prs;
   logic [2:0] deb_cnt [2];
   mode_e      state;
   logic [3:0] rep_cnt, rep_nxt;
   logic       inc_held, inc_evt, mode_evt;
   logic       sec_wrap, min_wrap;
   logic [1:0] hr_t_nx;
   logic [3:0] hr_u_nx, min_u_nx, sec_u_nx;
   logic [2:0] min_t_nx, sec_t_nx;

   assign tick_1hz   = sy_1hz[1]   & ~sy_1hz[2];
   assign tick_10hz  = sy_10hz[1]  & ~sy_10hz[2];
   assign tick_100hz = sy_100hz[1] & ~sy_100hz[2];

   // Bit 0 is the mode button, bit 1 the inc button; idle (released) level is 1.
   always_ff @(posedge clk_in) begin
      if (!rst) begin
         sy_1hz   <= '0;
         sy_10hz  <= '0;
         sy_100hz <= '0;
         btn_s1   <= 2'b11;
         btn_s2   <= 2'b11;
         btn_deb  <= 2'b11;
         btn_prs  <= 2'b00;
         for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
      end else begin
         sy_1hz   <= {sy_1hz[1:0], clk_1hz};
         sy_10hz  <= {sy_10hz[1:0], clk_10hz};
         sy_100hz <= {sy_100hz[1:0], clk_100hz};
         btn_s1   <= {btn_inc_n, btn_mode_n};
         btn_s2   <= btn_s1;
         btn_prs  <= 2'b00;
         if (tick_100hz) begin
            for (int i = 0; i < 2; i++) begin
               if (btn_s2[i] == btn_deb[i]) begin
                  deb_cnt[i] <= '0;
               end else if (deb_cnt[i] == DEB_LAST) begin
                  deb_cnt[i] <= '0;
                  btn_deb[i] <= btn_s2[i];
                  btn_prs[i] <= ~btn_s2[i];
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 3'd1;
               end
            end
         end
      end
   end

   assign mode_evt = btn_prs[0];
   assign inc_held = ~btn_deb[1];
   assign rep_nxt  = (rep_cnt == 4'd15) ? rep_cnt : rep_cnt + 4'd1;
   // Repeat fires on the tick that brings the held count up to the threshold.
   assign inc_evt  = btn_prs[1] | (tick_10hz & inc_held & (rep_nxt >= REP_THR));

   always_comb begin
      sec_wrap = (sec_t == 3'd5) && (sec_u == 4'd9);
      min_wrap = (min_t == 3'd5) && (min_u == 4'd9);

      sec_t_nx = sec_t;
      sec_u_nx = sec_u + 4'd1;
      if (sec_wrap) begin
         sec_t_nx = '0;
         sec_u_nx = '0;
      end else if (sec_u == 4'd9) begin
         sec_t_nx = sec_t + 3'd1;
         sec_u_nx = '0;
      end

      min_t_nx = min_t;
      min_u_nx = min_u + 4'd1;
      if (min_wrap) begin
         min_t_nx = '0;
         min_u_nx = '0;
      end else if (min_u == 4'd9) begin
         min_t_nx = min_t + 3'd1;
         min_u_nx = '0;
      end

      hr_t_nx = hr_t;
      hr_u_nx = hr_u + 4'd1;
      if ((hr_t == 2'd2) && (hr_u == 4'd3)) begin
         hr_t_nx = '0;
         hr_u_nx = '0;
      end else if (hr_u == 4'd9) begin
         hr_t_nx = hr_t + 2'd1;
         hr_u_nx = '0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst) begin
         state   <= RUN;
         hr_t    <= '0;
         hr_u    <= '0;
         min_t   <= '0;
         min_u   <= '0;
         sec_t   <= '0;
         sec_u   <= '0;
         blink   <= 1'b0;
         rep_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               rep_cnt <= '0;
               if (mode_evt) begin
                  state <= SET_HR;
                  sec_t <= '0;
                  sec_u <= '0;
                  blink <= sy_1hz[1];
               end else begin
                  blink <= 1'b0;
                  if (tick_1hz) begin
                     sec_t <= sec_t_nx;
                     sec_u <= sec_u_nx;
                     if (sec_wrap) begin
                        min_t <= min_t_nx;
                        min_u <= min_u_nx;
                        if (min_wrap) begin
                           hr_t <= hr_t_nx;
                           hr_u <= hr_u_nx;
                        end
                     end
                  end
               end
            end
            SET_HR, SET_MIN: begin
               if (mode_evt) begin
                  state   <= (state == SET_HR) ? SET_MIN : RUN;
                  rep_cnt <= '0;
                  blink   <= (state == SET_HR) & sy_1hz[1];
               end else begin
                  blink <= sy_1hz[1];
                  if (!inc_held)      rep_cnt <= '0;
                  else if (tick_10hz) rep_cnt <= rep_nxt;
                  if (inc_evt) begin
                     if (state == SET_HR) begin
                        hr_t <= hr_t_nx;
                        hr_u <= hr_u_nx;
                     end else begin
                        min_t <= min_t_nx;
                        min_u <= min_u_nx;
                     end
                  end
               end
            end
            default: begin
               state   <= RUN;
               blink   <= 1'b0;
               rep_cnt <= '0;
            end
         endcase
      end
   end

   assign mode = state;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Directed bench for watch_timekeeper: a time-of-day model checked every cycle,
// plus hand-computed checkpoints along the set/run scenarios.
module tb_watch_timekeeper;

   localparam int DEB_N = 2;
   localparam int REP_D = 5;

   logic       clk_in     = 1'b0;
   logic       rst        = 1'b0;
   logic       clk_1hz    = 1'b0;
   logic       clk_10hz   = 1'b0;
   logic       clk_100hz  = 1'b0;
   logic       btn_mode_n = 1'b1;
   logic       btn_inc_n  = 1'b1;
   logic [1:0] hr_t;
   logic [3:0] hr_u;
   logic [2:0] min_t;
   logic [3:0] min_u;
   logic [2:0] sec_t;
   logic [3:0] sec_u;
   logic [1:0] mode;
   logic       blink;

   int  n_vec  = 0;
   int  n_bad  = 0;
   bit  chk_en = 1'b0;

   watch_timekeeper #(.REPEAT_DELAY(REP_D), .DEBOUNCE_N(DEB_N)) dut (
      .clk_in(clk_in), .rst(rst),
      .clk_1hz(clk_1hz), .clk_10hz(clk_10hz), .clk_100hz(clk_100hz),
      .btn_mode_n(btn_mode_n), .btn_inc_n(btn_inc_n),
      .hr_t(hr_t), .hr_u(hr_u), .min_t(min_t), .min_u(min_u),
      .sec_t(sec_t), .sec_u(sec_u), .mode(mode), .blink(blink)
   );

   always #10 clk_in = ~clk_in;

   // Model: time of day as plain integers, inputs seen through a sampled history.
   int  m_hh, m_mm, m_ss, m_mode, m_rep;
   bit  m_blink;
   bit  h1 [3];
   bit  h10 [3];
   bit  h100 [3];
   bit  hm [3];
   bit  hi [3];
   int  run_m, run_i;
   bit  deb_m, deb_i, evt_m, evt_i;

   always @(posedge clk_in) begin : model
      bit t1, t10, t100, held, fire, nm, ni;
      int rn, tod;
      if (!rst) begin
         m_hh = 0; m_mm = 0; m_ss = 0; m_mode = 0; m_rep = 0; m_blink = 0;
         for (int k = 0; k < 3; k++) begin
            h1[k] = 0; h10[k] = 0; h100[k] = 0; hm[k] = 1; hi[k] = 1;
         end
         run_m = 0; run_i = 0; deb_m = 1; deb_i = 1; evt_m = 0; evt_i = 0;
      end else begin
         t1   = h1[1] && !h1[2];
         t10  = h10[1] && !h10[2];
         t100 = h100[1] && !h100[2];
         held = !deb_i;
         rn   = (m_rep < 15) ? m_rep + 1 : 15;
         fire = evt_i || (t10 && held && rn >= REP_D);
         if (m_mode == 0) begin
            m_rep = 0;
            if (evt_m) begin
               m_mode = 1;
               m_ss   = 0;
            end else if (t1) begin
               tod  = (m_hh * 3600 + m_mm * 60 + m_ss + 1) % 86400;
               m_hh = tod / 3600;
               m_mm = (tod / 60) % 60;
               m_ss = tod % 60;
            end
         end else if (evt_m) begin
            m_mode = (m_mode == 1) ? 2 : 0;
            m_rep  = 0;
         end else begin
            m_rep = held ? (t10 ? rn : m_rep) : 0;
            if (fire) begin
               if (m_mode == 1) m_hh = (m_hh + 1) % 24;
               else             m_mm = (m_mm + 1) % 60;
            end
         end
         m_blink = (m_mode != 0) && h1[1];
         nm = 0;
         ni = 0;
         if (t100) begin
            if (hm[1] != deb_m) begin
               run_m++;
               if (run_m == DEB_N) begin deb_m = hm[1]; run_m = 0; nm = !hm[1]; end
            end else run_m = 0;
            if (hi[1] != deb_i) begin
               run_i++;
               if (run_i == DEB_N) begin deb_i = hi[1]; run_i = 0; ni = !hi[1]; end
            end else run_i = 0;
         end
         evt_m = nm;
         evt_i = ni;
         h1[2] = h1[1];     h1[1] = h1[0];     h1[0] = clk_1hz;
         h10[2] = h10[1];   h10[1] = h10[0];   h10[0] = clk_10hz;
         h100[2] = h100[1]; h100[1] = h100[0]; h100[0] = clk_100hz;
         hm[2] = hm[1];     hm[1] = hm[0];     hm[0] = btn_mode_n;
         hi[2] = hi[1];     hi[1] = hi[0];     hi[0] = btn_inc_n;
      end
   end

   logic [22:0] got_v, exp_v;

   always @(negedge clk_in) begin
      if (chk_en) begin
         got_v = {hr_t, hr_u, min_t, min_u, sec_t, sec_u, mode, blink};
         exp_v = {2'(m_hh / 10), 4'(m_hh % 10), 3'(m_mm / 10), 4'(m_mm % 10),
                  3'(m_ss / 10), 4'(m_ss % 10), 2'(m_mode), m_blink};
         n_vec++;
         if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL cycle t=%0t: got %0d%0d:%0d%0d:%0d%0d mode=%0d blink=%0d, expected %0d:%0d:%0d mode=%0d blink=%0d",
                     $time, hr_t, hr_u, min_t, min_u, sec_t, sec_u, mode, blink,
                     m_hh, m_mm, m_ss, m_mode, m_blink);
         end
      end
   end

   function automatic int dut_time();
      return hr_t * 100000 + hr_u * 10000 + min_t * 1000 + min_u * 100 + sec_t * 10 + sec_u;
   endfunction

   task automatic lit(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic pulse_1hz();
      @(negedge clk_in); clk_1hz = 1'b1; cyc(4); clk_1hz = 1'b0; cyc(4);
   endtask

   task automatic pulse_10hz();
      @(negedge clk_in); clk_10hz = 1'b1; cyc(4); clk_10hz = 1'b0; cyc(4);
   endtask

   task automatic pulse_100hz();
      @(negedge clk_in); clk_100hz = 1'b1; cyc(4); clk_100hz = 1'b0; cyc(4);
   endtask

   task automatic press(input bit inc);
      if (inc) btn_inc_n = 1'b0;
      else     btn_mode_n = 1'b0;
      repeat (3) pulse_100hz();
      btn_inc_n  = 1'b1;
      btn_mode_n = 1'b1;
      repeat (3) pulse_100hz();
   endtask

   initial begin
      // T1: reset
      cyc(1);
      chk_en = 1'b1;
      cyc(2);
      rst = 1'b1;
      cyc(1);
      lit("t1_time", dut_time(), 0);
      lit("t1_mode", mode, 0);
      lit("t1_blink", blink, 0);

      // T2: 59 seconds, then the minute carry with its three-edge latency
      repeat (59) pulse_1hz();
      lit("t2_time59", dut_time(), 59);
      @(negedge clk_in); clk_1hz = 1'b1;
      @(posedge clk_in); #1 lit("t2_e1", dut_time(), 59);
      @(posedge clk_in); #1 lit("t2_e2", dut_time(), 59);
      @(posedge clk_in); #1 lit("t2_e3", dut_time(), 100);
      cyc(3); clk_1hz = 1'b0; cyc(4);

      // T4: enter SET_HR, seconds frozen, blink follows 1 Hz
      press(1'b0);
      lit("t4_mode", mode, 1);
      lit("t4_time", dut_time(), 100);
      @(negedge clk_in); clk_1hz = 1'b1; cyc(4);
      lit("t4_blink_hi", blink, 1);
      clk_1hz = 1'b0; cyc(4);
      lit("t4_blink_lo", blink, 0);
      pulse_1hz();
      lit("t4_sec_held", dut_time(), 100);

      // T5: hours 22 -> 23 -> 00, minutes 59 -> 00
      repeat (22) press(1'b1);
      lit("t5_hr22", dut_time(), 220100);
      press(1'b1);
      lit("t5_hr23", dut_time(), 230100);
      press(1'b1);
      lit("t5_hr00", dut_time(), 100);
      repeat (23) press(1'b1);
      press(1'b0);
      lit("t5_mode_min", mode, 2);
      repeat (58) press(1'b1);
      lit("t5_min59", dut_time(), 235900);
      press(1'b1);
      lit("t5_min00", dut_time(), 230000);

      // auto-repeat back up to 59, then run to midnight (T3)
      btn_inc_n = 1'b0;
      repeat (3) pulse_100hz();
      lit("rep_first", dut_time(), 230100);
      repeat (62) pulse_10hz();
      lit("rep_59", dut_time(), 235900);
      btn_inc_n = 1'b1;
      repeat (3) pulse_100hz();
      press(1'b0);
      lit("t3_mode_run", mode, 0);
      repeat (58) pulse_1hz();
      lit("t3_235958", dut_time(), 235958);
      pulse_1hz();
      lit("t3_235959", dut_time(), 235959);
      pulse_1hz();
      lit("t3_midnight", dut_time(), 0);

      // T6: SET_MIN at 10, held inc, reset mid-hold
      press(1'b0);
      press(1'b0);
      lit("t6_mode_min", mode, 2);
      repeat (10) press(1'b1);
      lit("t6_min10", dut_time(), 1000);
      btn_inc_n = 1'b0;
      repeat (3) pulse_100hz();
      lit("t6_min11", dut_time(), 1100);
      repeat (12) pulse_10hz();
      lit("t6_min19", dut_time(), 1900);
      @(negedge clk_in); rst = 1'b0;
      cyc(2);
      rst = 1'b1;
      cyc(1);
      lit("t6_rst_time", dut_time(), 0);
      lit("t6_rst_mode", mode, 0);
      repeat (2) pulse_10hz();
      btn_inc_n = 1'b1;
      repeat (3) pulse_100hz();
      lit("t6_after_rel", dut_time(), 0);
      pulse_1hz();
      lit("t6_counting", dut_time(), 1);

      cyc(2);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
